// File: rtl/lab2_nibble_serial_cla_adder.sv
// Nibble-serial two's-complement adder.
// A single 4-bit carry-lookahead slice is reused once per clock, least
// significant nibble first, so a WIDTH-bit add costs NIBBLES cycles but
// only one slice of lookahead logic. Results are held until the next accept.
module lab2_nibble_serial_cla_adder #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bit offset of the nibble currently being processed.
  logic [IDXW+1:0]  nib_base;
  logic [3:0]       nib_a, nib_b, nib_g, nib_p, nib_sum;
  logic             c1, c2, c3, c4;
  logic             accept;

  assign nib_base = {idx_q, 2'b00};
  assign accept   = start && (state_q != ST_RUN);

  // Carry-lookahead slice: every carry is a flat sum of products of the
  // generate/propagate terms and the incoming carry, with no ripple chain.
  always_comb begin
    nib_a   = a_q[nib_base +: 4];
    nib_b   = b_q[nib_base +: 4];
    nib_g   = nib_a & nib_b;
    nib_p   = nib_a ^ nib_b;
    c1      = nib_g[0]
            | (nib_p[0] & carry_q);
    c2      = nib_g[1]
            | (nib_p[1] & nib_g[0])
            | (nib_p[1] & nib_p[0] & carry_q);
    c3      = nib_g[2]
            | (nib_p[2] & nib_g[1])
            | (nib_p[2] & nib_p[1] & nib_g[0])
            | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    c4      = nib_g[3]
            | (nib_p[3] & nib_g[2])
            | (nib_p[3] & nib_p[2] & nib_g[1])
            | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
            | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    nib_sum = nib_p ^ {c3, c2, c1, carry_q};
  end

  // Next-state and next-register logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (accept) begin
      a_d     = A;
      b_d     = B;
      carry_d = cin;
      s_d     = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      idx_d   = '0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          s_d[nib_base +: 4] = nib_sum;
          carry_d            = c4;
          idx_d              = idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            cout_d  = c4;
            ovf_d   = c4 ^ c3;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // All state and outputs registered; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_lab2_nibble_serial_cla_adder.sv
// Directed self-checking bench for the nibble-serial CLA adder (NIBBLES=4).
module tb_lab2_nibble_serial_cla_adder;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          cin = 1'b0;
  logic [W-1:0]  s_out;
  logic          cout;
  logic          ovf;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  lab2_nibble_serial_cla_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .cin   (cin),
    .S     (s_out),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts and reports via an immediate assertion.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,S} = A+B+cin; ovf when like-signed operands give an unlike-signed sum.
  function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] sum;
    logic       v;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    return {v, sum};
  endfunction

  // Present operands at a negedge and hold start across exactly one rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    cin   = 1'($urandom);
  endtask

  // Wait (bounded) for done, checking busy lasted 4 cycles and the result.
  task automatic checkOutput(input string tag, input logic [W-1:0] exp_s,
                             input logic exp_c, input logic exp_v);
    int busy_cycles = 0;
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cycles++;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd4);
    check_eq({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check_eq({tag, "_S"}, 32'(s_out), 32'(exp_s));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp_c));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_v));
  endtask

  logic [W-1:0] vec_a [0:20];
  logic [W-1:0] vec_b [0:20];
  logic         vec_c [0:20];

  initial begin
    logic [17:0] m;
    logic [W-1:0] ra, rb;
    logic rc;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_S", 32'(s_out), 32'h0);
    check_eq("rst_cout", 32'(cout), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic add with hold through idle
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkOutput("basic", 16'h5555, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_done_low", 32'(done), 32'h0);
      check_eq("hold_S", 32'(s_out), 32'h5555);
    end

    // Carry crossing every nibble boundary
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    checkOutput("fullcarry", 16'h0000, 1'b1, 1'b0);

    // Signed overflow cases
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOutput("ovf_pos", 16'h8000, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    checkOutput("ovf_neg", 16'h0000, 1'b1, 1'b1);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    checkOutput("neg_noovf", 16'hFFFF, 1'b1, 1'b0);

    // Start held high, operands changing each cycle: accepts every 5 edges
    repeat (2) @(negedge clk);
    for (int j = 0; j <= 20; j++) begin
      vec_a[j] = $urandom;
      vec_b[j] = $urandom;
      vec_c[j] = 1'($urandom);
    end
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        check_eq("b2b_done", 32'(done), 32'(((j - 1) % 5) == 4));
        check_eq("b2b_busy", 32'(busy), 32'(((j - 1) % 5) != 4));
        if (((j - 1) % 5) == 4) begin
          m = model(vec_a[j-5], vec_b[j-5], vec_c[j-5]);
          check_eq("b2b_S", 32'(s_out), 32'(m[15:0]));
          check_eq("b2b_cout", 32'(cout), 32'(m[16]));
          check_eq("b2b_ovf", 32'(ovf), 32'(m[17]));
        end
      end
      a_in  = vec_a[j];
      b_in  = vec_b[j];
      cin   = vec_c[j];
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    m = model(vec_a[20], vec_b[20], vec_c[20]);
    checkOutput("b2b_last", m[15:0], m[16], m[17]);

    // Reset two cycles into an operation
    applyStimulus(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("mid_partial_S", 32'(s_out), 32'h00DE);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_S", 32'(s_out), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_done", 32'(done), 32'h0);
    check_eq("mid_rst_cout", 32'(cout), 32'h0);
    check_eq("mid_rst_ovf", 32'(ovf), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("in_rst_done", 32'(done), 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_idle_busy", 32'(busy), 32'h0);
      check_eq("post_rst_idle_done", 32'(done), 32'h0);
    end
    applyStimulus(16'hABCD, 16'h1111, 1'b0);
    checkOutput("after_rst", 16'hBCDE, 1'b0, 1'b0);

    // Random operands against the arithmetic reference
    for (int k = 0; k < 200; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      m  = model(ra, rb, rc);
      applyStimulus(ra, rb, rc);
      checkOutput("random", m[15:0], m[16], m[17]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lab2_nibble_serial_cla_adder.md
# lab2_nibble_serial_cla_adder

Nibble-serial two's-complement adder, the additive counterpart to the team's 4-bit borrow-lookahead subtractor. It accepts two WIDTH-bit operands and a carry-in on a start strobe. It then processes one 4-bit nibble per clock through a single 4-bit carry-lookahead slice, starting with the least significant nibble, and holds the result. It feeds the lab ALU datapath wherever area matters more than single-cycle latency.

## Interface
- NIBBLES, 4, number of 4-bit slices; WIDTH = 4*NIBBLES (default 16); legal range 1..8
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin an addition; sampled only when the block is ready (state IDLE or DONE)
- A  input  WIDTH  augend; sampled on the accepting edge only
- B  input  WIDTH  addend; sampled on the accepting edge only
- cin  input  1  carry-in; sampled on the accepting edge only
- S  output  WIDTH  sum register
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid

## Operation
- Reset asserted (asynchronous, any state): state=IDLE, S=0, cout=0, ovf=0, busy=0, done=0, nibble index=0, internal carry=0, operand registers=0.
- States:
  - IDLE: waits for start.
  - RUN: processes nibbles.
  - DONE: lasts one cycle, done=1.
- Accept: start=1 at a clock edge while in IDLE or DONE.
  - A and B are latched; cin goes into the carry register.
  - S, cout and ovf are cleared; index=0.
  - Next state is RUN.
- start while in RUN is ignored. Operand changes during RUN have no effect.
- RUN edge with index i:
  - The slice takes a=Areg[4i+3:4i], b=Breg[4i+3:4i] and carry c0 = the carry register.
  - Per bit: g=a&b, p=a^b.
  - c1=g0|p0c0, c2=g1|p1g0|p1p0c0, c3 and c4 follow the same full lookahead expansion, with no ripple chaining.
  - Nibble sum = p^{c3,c2,c1,c0}. It is written to S[4i+3:4i]; other nibbles of S are unchanged.
  - The carry register takes c4; index increments.
- Last nibble (i=NIBBLES-1), same edge:
  - cout=c4.
  - ovf = c4 ^ c3, i.e. the carry into the MSB XOR the carry out of the MSB.
  - Next state is DONE.
- DONE: done=1, busy=0.
  - Without start, the next state is IDLE.
  - With start, the new operands are accepted and the next state is RUN (back-to-back).
- S, cout and ovf hold their value through IDLE until the next accept.
- Arithmetic: {cout,S} = A + B + cin, modulo 2^(WIDTH+1). Operands are unsigned for cout and two's-complement for ovf.

## Timing
- Accept at edge k. Nibble i is written at edge k+1+i. Last nibble at edge k+NIBBLES.
- done is high during the cycle after edge k+NIBBLES. Latency from the accepting edge to done is NIBBLES cycles.
- busy is high from edge k+1 through edge k+NIBBLES, exclusive of DONE.
- Minimum start-to-start period: NIBBLES+1 cycles, achieved by asserting start during DONE.
- Outputs are registered; there is no combinational path from any input to any output.
- Reset mid-RUN: the partial S is discarded (S=0), no done pulse is issued, and the first edge after release needs start to begin again.

## Test plan
- Reset, then A=16'h1234, B=16'h4321, cin=0, start for one cycle:
  - busy for 4 cycles, then a single done pulse.
  - S=16'h5555, cout=0, ovf=0.
  - S holds for 10 idle cycles.
- Full carry propagation, A=16'hFFFF, B=16'h0000, cin=1:
  - S=16'h0000, cout=1, ovf=0.
  - The carry must cross all four nibble boundaries.
- Signed overflow:
  - A=16'h7FFF, B=16'h0001, cin=0: S=16'h8000, cout=0, ovf=1.
  - A=16'h8000, B=16'h8000: S=0, cout=1, ovf=1.
- Back-to-back and ignored start:
  - start held high continuously with A/B changing every cycle: accepts occur every 5 cycles, only on IDLE/DONE edges.
  - Each result matches the operands sampled at its accepting edge.
- Reset mid-operation:
  - Assert rst_n=0 two cycles after accepting A=16'hABCD, B=16'h1111.
  - All outputs are 0 immediately and asynchronously, with no done pulse.
  - A fresh start then gives correct results.
- Random: 10,000 random A/B/cin triples compared against A+B+cin for the carry and XOR-of-sign-carries for ovf.
  - Repeat with NIBBLES=1 and NIBBLES=8.
